// File: rtl/rv_pkg.sv
// ----------------------------------------------------------------------------
// rv_pkg: constants shared by the instruction decoder and the multiply/divide
// unit.
//   OPC_OP / F7_MULDIV : encoding that sends an OP instruction to muldiv_unit
//   F3_*               : funct3 selects for the eight M-extension operations
//   md_state_e         : muldiv_unit FSM states
//   a_is_signed/b_is_signed : operand signedness for a given funct3
// ----------------------------------------------------------------------------
package rv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } md_state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV)  || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit: iterative RV32M multiply/divide unit. The unit takes one
// operation at a time, runs 32 shift-add or restoring-divide iterations, then
// applies sign correction and returns a held result with a one-cycle done
// pulse. Divide by zero and signed overflow finish in one cycle.
//   clk     in   rising-edge clock
//   rst     in   synchronous active-high reset
//   start   in   request strobe, sampled only when not busy
//   flush   in   squash: aborts the in-flight operation, suppresses done
//   funct3  in   M-op select (rv_pkg::F3_*)
//   op_a    in   rs1 (multiplicand / dividend)
//   op_b    in   rs2 (multiplier / divisor)
//   busy    out  high in CALC and FIX
//   done    out  one-cycle pulse, result valid
//   result  out  held from done until the next accepted start
// ----------------------------------------------------------------------------
module muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN-1:0] acc_q;      // mul: product; div: remainder:quotient
    logic [XLEN-1:0]   opnd_q;     // |multiplicand| or |divisor|
    logic [2:0]        f3_q;
    logic              neg_a_q;
    logic              neg_b_q;
    logic [XLEN-1:0]   result_q;

    // Accept-time decode of the incoming request.
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              fast;
    logic [XLEN-1:0]   fast_res;

    // Iteration and correction datapath.
    logic              is_div;
    logic [XLEN:0]     addsub_a;
    logic [XLEN:0]     addsub_r;
    logic [2*XLEN-1:0] acc_d;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   result_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        neg_a    = a_is_signed(funct3) & op_a[XLEN-1];
        neg_b    = b_is_signed(funct3) & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        fast     = 1'b0;
        fast_res = '0;
        if (funct3[2] && op_b == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            fast     = 1'b1;
            fast_res = funct3[1] ? op_a : '1;
        end else if (funct3[2] && !funct3[0] && op_a == MIN_NEG && op_b == '1) begin
            // Signed overflow: quotient is the dividend, remainder zero.
            fast     = 1'b1;
            fast_res = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One shared adder/subtractor. Multiply adds the multiplicand into the
    // upper half; divide trial-subtracts the divisor from the shifted-in
    // remainder (33 bits, because the shifted remainder can exceed XLEN bits).
    always_comb begin
        is_div   = f3_q[2];
        addsub_a = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        addsub_r = is_div ? addsub_a - {1'b0, opnd_q} : addsub_a + {1'b0, opnd_q};
        if (is_div) begin
            // Borrow means the trial failed: restore by shifting only.
            acc_d = addsub_r[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {addsub_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_d = acc_q[0] ? {addsub_r, acc_q[XLEN-1:1]}
                             : {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                        result_d = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  result_d = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               result_d = quot;
            default:                       result_d = rem;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        f3_q    <= funct3;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        cnt_q   <= '0;
                        if (fast) begin
                            result_q <= fast_res;
                            state_q  <= DONE;
                        end else begin
                            // Divide shifts the dividend out of the low half;
                            // multiply shifts the multiplier out of it.
                            acc_q   <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                            opnd_q  <= funct3[2] ? mag_b : mag_a;
                            state_q <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= result_d;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q == CALC) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit: directed self-checking bench for muldiv_unit. Inputs change
// on the falling edge; outputs are sampled 1ns after the rising edge. In the
// latency counts, cycle 1 is the cycle right after the accepting edge.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    import rv_pkg::*;

    localparam int XLEN = 32;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Present a request for one edge; returns 1ns after the accepting edge.
    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles (current = 1) until done, bounded at 40. lat=0 on timeout.
    task automatic wait_done(output int lat, output int busy_cyc, output logic [31:0] res);
        lat      = 0;
        busy_cyc = 0;
        res      = 'x;
        for (int k = 1; k <= 40; k++) begin
            if (busy) busy_cyc++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Shared body for table-driven operations: result, latency, busy cycles,
    // and that done drops with result held the following cycle.
    task automatic test_table(input string name, input vec_t v[], input int exp_lat, input int exp_busy);
        int lat, bc;
        logic [31:0] res;
        foreach (v[i]) begin
            launch(v[i].f3, v[i].a, v[i].b);
            wait_done(lat, bc, res);
            tests_run++;
            if (res !== v[i].exp || lat != exp_lat || bc != exp_busy) begin
                tests_failed++;
                $display("FAIL %s[%0d]: result=%h lat=%0d busy=%0d, expected %h lat=%0d busy=%0d",
                         name, i, res, lat, bc, v[i].exp, exp_lat, exp_busy);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (done !== 1'b0 || result !== v[i].exp) begin
                tests_failed++;
                $display("FAIL %s[%0d] hold: done=%b result=%h, expected 0 %h", name, i, done, result, v[i].exp);
            end
        end
    endtask

    task automatic test_multiply();
        vec_t v[] = '{
            '{F3_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
            '{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000},
            '{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE}
        };
        test_table("mul", v, 34, 33);
    endtask

    task automatic test_divide();
        vec_t v[] = '{
            '{F3_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
            '{F3_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
            '{F3_DIVU, 32'd100,      32'd7,        32'd14},
            '{F3_REMU, 32'd100,      32'd7,        32'd2},
            '{F3_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD},
            '{F3_REM,  32'd7,        32'hFFFFFFFE, 32'd1}
        };
        test_table("div", v, 34, 33);
    endtask

    task automatic test_fast_path();
        vec_t v[] = '{
            '{F3_DIV,  32'd5,        32'd0,        32'hFFFFFFFF},
            '{F3_REMU, 32'd5,        32'd0,        32'd5},
            '{F3_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000},
            '{F3_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0}
        };
        test_table("fast", v, 1, 0);
    endtask

    task automatic test_flush();
        int lat, bc, n_done;
        logic [31:0] res;
        launch(F3_DIVU, 32'd5, 32'd0);        // establishes result = FFFFFFFF
        wait_done(lat, bc, res);
        launch(F3_MUL, 32'd7, 32'hFFFFFFFD);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL flush: busy=%b done=%b result=%h, expected 0 0 ffffffff", busy, done, result);
        end
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL flush no-done: saw %0d done pulses, expected 0", n_done);
        end
        launch(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bc, res);
        tests_run++;
        if (res !== 32'hFFFFFFFE || lat != 34) begin
            tests_failed++;
            $display("FAIL flush restart: result=%h lat=%0d, expected fffffffe lat=34", res, lat);
        end
        // Flush together with start while idle: a fast-path op must not be accepted.
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        funct3 = F3_DIV; op_a = 32'd5; op_b = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFFFFFE) begin
            tests_failed++;
            $display("FAIL flush+start: busy=%b done=%b result=%h, expected 0 0 fffffffe", busy, done, result);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, bc;
        logic [31:0] res;
        launch(F3_DIVU, 32'd100, 32'd7);       // now cycle 1
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        launch(F3_DIV, 32'd5, 32'd0);          // would finish at once if accepted; now cycle 6
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy-start: busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_done(lat, bc, res);
        tests_run++;
        if (res !== 32'd14 || lat != 29) begin
            tests_failed++;
            $display("FAIL busy-start result: result=%h lat=%0d, expected 0000000e lat=29", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] res;
        launch(F3_MUL, 32'd7, 32'hFFFFFFFD);
        wait_done(lat, bc, res);
        // Still inside the DONE cycle: present the next request now.
        start = 1'b1; funct3 = F3_REMU; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        tests_run++;
        if (res !== 32'hFFFFFFEB || busy !== 1'b1 || result !== 32'hFFFFFFEB) begin
            tests_failed++;
            $display("FAIL b2b accept: first=%h busy=%b result=%h, expected ffffffeb 1 ffffffeb", res, busy, result);
        end
        wait_done(lat, bc, res);
        tests_run++;
        if (res !== 32'd2 || lat != 34) begin
            tests_failed++;
            $display("FAIL b2b second: result=%h lat=%0d, expected 00000002 lat=34", res, lat);
        end
    endtask

    task automatic test_reset_mid_fix();
        launch(F3_MUL, 32'd7, 32'hFFFFFFFD);
        repeat (32) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fix busy: busy=%b, expected 1", busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst mid-fix: busy=%b done=%b result=%h, expected 0 0 00000000", busy, done, result);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide();
        test_fast_path();
        test_flush();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_fix();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit: accepts one M-extension operation (opcode 0110011, funct7 0000001, the encodings the ALU decoder does not handle), computes it over 32 iteration cycles with a shift-add / restoring-divide FSM, and returns a held result with a one-cycle done pulse. It sits beside the ALU in the execute stage. The pipeline stalls on busy and captures result on done.

## Interface
- XLEN, 32, operand/result width. The iteration counter is $clog2(XLEN) bits wide.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only when the unit is not busy.
- flush  in  1  pipeline squash; aborts the in-flight operation.
- funct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (multiplicand/dividend).
- op_b  in  XLEN  rs2 value (multiplier/divisor).
- busy  out  1  high in states CALC and FIX.
- done  out  1  one-cycle pulse; result valid this cycle.
- result  out  XLEN  held from done until the next accepted start.

## Operation
- States:
  - IDLE: waits for start.
  - CALC: 32 iterations.
  - FIX: sign correction and result select.
  - DONE: pulses done.
- Transitions:
  - IDLE or DONE with start=1 → CALC, or → DONE on the fast path.
  - CALC → FIX when the counter reaches XLEN-1.
  - FIX → DONE.
  - DONE with start=0 → IDLE.
- On accept, the unit latches funct3 and operand magnitudes plus sign flags:
  - a is signed for MULH, MULHSU, DIV and REM.
  - b is signed for MULH, DIV and REM.
- Multiply: unsigned 2·XLEN product via shift-add, one multiplier bit per cycle.
  - FIX negates the product if the sign flags differ.
  - MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: unsigned restoring division, one quotient bit per cycle.
  - FIX negates the quotient if the sign flags differ.
  - FIX negates the remainder if the dividend was negative.
- Fast path (no CALC/FIX), decided at accept:
  - divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- start while busy is ignored; the upstream stage holds the request until it is accepted.
- flush has priority over start and over FSM progress:
  - forces IDLE and suppresses done; result is unchanged.
  - flush together with start in IDLE/DONE: start is not accepted.
- rst has priority over everything. Reset values: state IDLE, busy 0, done 0, result 0, counter 0.

## Timing
- Start sampled high at edge T (normal path):
  - CALC occupies T+1..T+32 and FIX occupies T+33. busy=1 for those cycles.
  - DONE at T+34: done=1, busy=0, result valid.
- Fast path: DONE at T+1; busy stays 0.
- Back-to-back: a start sampled in the DONE cycle is accepted, so throughput is one operation per 34 cycles.
- result updates only on the edge that enters DONE and is stable otherwise.
- Outputs are registered or decoded from state only. There is no combinational path from any input to busy, done or result.
- Reset or flush asserted mid-CALC: the next cycle is IDLE, busy=0, and no done for the aborted operation.

## Structure
- Shared package rv_pkg holds:
  - OPC_OP = 7'b0110011 and F7_MULDIV = 7'b0000001.
  - funct3 localparams for the eight M ops.
  - the FSM state enum (IDLE, CALC, FIX, DONE).
- The decoder uses the same package constants to steer M ops here instead of to the ALU.
- Single module with no sub-module. The datapath is small enough to sit inline with the FSM:
  - one 2·XLEN accumulator shared by multiply (product) and divide (remainder:quotient).
  - one XLEN adder/subtractor.

## Test plan
- MUL 7×-3 and MULH 0x80000000×0x80000000 → 0xFFFFFFEB (−21) and 0x40000000; done exactly 34 cycles after start; busy high for 33 cycles.
- MULHSU 0xFFFFFFFF(−1)×0xFFFFFFFF and MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF and 0xFFFFFFFE.
- DIV −7/2, REM −7/2, DIVU 100/7, REMU 100/7 → 0xFFFFFFFD, 0xFFFFFFFF, 14, 2.
- Fast path:
  - DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5.
  - DIV 0x80000000/−1 → 0x80000000 and REM → 0.
  - Each gives done at T+1 with busy never high.
- Flush at CALC cycle 10 → IDLE next cycle, no done, result keeps the prior value. A restart then completes normally.
- start pulsed while busy is ignored. start held in the DONE cycle is accepted back-to-back. rst mid-FIX → busy=0, done=0, result=0 next cycle.
